// File: rtl/hazard_pkg.sv
// Shared types and default producer latencies for the RAW-hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    OPC_ALU  = 2'd0,
    OPC_LOAD = 2'd1,
    OPC_MUL  = 2'd2,
    OPC_CSR  = 2'd3
  } op_class_e;

  localparam int DEF_LAT_ALU  = 0;
  localparam int DEF_LAT_LOAD = 1;
  localparam int DEF_LAT_MUL  = 3;
  localparam int DEF_LAT_CSR  = 1;

endpackage

// File: rtl/hz_cnt_entry.sv
// One scoreboard entry: cycles remaining until the in-flight result for a
// register is forwardable, plus the class of the producer that owns it.
module hz_cnt_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic [1:0]       load_cls,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       cls
);

  // NOTE: every entry sits on the async reset; a pending hazard must never
  // survive reset, so this storage cannot be left uninitialised like a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      cls <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (hold) begin
      // NOTE: sequential state uses <= so all entries sample the same
      // pre-edge values regardless of block evaluation order.
      cnt <= cnt;
    end else if (load) begin
      // Youngest writer wins, even over a countdown expiring this cycle.
      cnt <= load_cnt;
      cls <= load_cls;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register RAW interlock for ID with per-class producer latency.
// Define HAZARD_PERF_EN to add the stall-cycle and load-stall perf counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LAT_ALU    = DEF_LAT_ALU,
  parameter int LAT_LOAD   = DEF_LAT_LOAD,
  parameter int LAT_MUL    = DEF_LAT_MUL,
  parameter int LAT_CSR    = DEF_LAT_CSR,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  rd_we,
  input  logic [1:0]            op_class,
  input  logic                  pipe_hold,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            stall_cls,
  output logic [NUM_REGS-1:0]   busy_vec
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_ld_stall
`endif
);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [1:0]       cls_q [NUM_REGS];
  logic [CNT_W-1:0] new_cnt;
  logic             hit1, hit2, fire;

  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] opc);
    logic [CNT_W-1:0] l;
    l = CNT_W'(LAT_ALU);
    case (op_class_e'(opc))
      OPC_ALU:  l = CNT_W'(LAT_ALU);
      OPC_LOAD: l = CNT_W'(LAT_LOAD);
      OPC_MUL:  l = CNT_W'(LAT_MUL);
      OPC_CSR:  l = CNT_W'(LAT_CSR);
      default:  l = CNT_W'(LAT_ALU);
    endcase
    return l;
  endfunction

  assign new_cnt  = lat_of(op_class);
  assign cnt_q[0] = '0;
  assign cls_q[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hz_cnt_entry #(.CNT_W(CNT_W)) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flush),
      .hold     (pipe_hold),
      .load     (fire && rd_we && (rd_addr == REG_ADDR_W'(r))),
      .load_cnt (new_cnt),
      .load_cls (op_class),
      .cnt      (cnt_q[r]),
      .cls      (cls_q[r])
    );
  end

  // Hazard checks see pre-update state, so an instruction never stalls on itself.
  assign hit1  = rs1_used && (rs1_addr != '0) && (cnt_q[rs1_addr] != '0);
  assign hit2  = rs2_used && (rs2_addr != '0) && (cnt_q[rs2_addr] != '0);
  assign stall = id_valid && !flush && (hit1 || hit2);
  assign fire  = id_valid && !stall && !pipe_hold && !flush;

  // NOTE: every output of an always_comb is given a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    stall_cls = '0;
    if (hit1)      stall_cls = cls_q[rs1_addr];
    else if (hit2) stall_cls = cls_q[rs2_addr];
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_vec[r] = (cnt_q[r] != '0);
  end

`ifdef HAZARD_PERF_EN
  // Cleared by reset only; flush does not disturb the statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_ld_stall  <= '0;
    end else if (stall) begin
      perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (stall_cls == OPC_LOAD) perf_ld_stall <= perf_ld_stall + 32'd1;
    end
  end
`endif

endmodule
